// File: rtl/show_rect_draw.sv
// Rasterises clear-rows and rectangle commands into overlay RAM pixel writes.
// Optional macro RECT_FILL_EN: rectangles are filled instead of outlined.
`ifndef ASCII_WIDTH
`define ASCII_WIDTH 8
`endif
`ifndef LETTER_PIXEL_WIDTH
`define LETTER_PIXEL_WIDTH 8
`endif

module show_rect_draw #(
   parameter int A_W = `ASCII_WIDTH,
   parameter int L_W = `LETTER_PIXEL_WIDTH
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             i_cmd_valid,
   input  logic [A_W-1:0]   i_ascii,
   input  logic [2:0]       i_color,
   input  logic [L_W-1:0]   i_ys,
   input  logic [L_W-1:0]   i_ye,
   input  logic [L_W-1:0]   i_x1,
   input  logic [L_W-1:0]   i_y1,
   input  logic [L_W-1:0]   i_x2,
   input  logic [L_W-1:0]   i_y2,
   output logic             o_wr_en,
   output logic [2*L_W-1:0] o_wr_addr,
   output logic [2:0]       o_wr_data,
   output logic             o_busy,
   output logic             o_drop
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      TOP,
      BOTTOM,
      LEFT,
      RIGHT
`ifdef RECT_FILL_EN
      , FILL
`endif
   } state_t;

   localparam logic [L_W-1:0] ONE  = L_W'(1);
   localparam logic [L_W-1:0] TWO  = L_W'(2);
   localparam logic [L_W-1:0] MAXV = '1;

   state_t state_q, state_d;
   logic [L_W-1:0] x_q, x_d, y_q, y_d;
   logic [L_W-1:0] xl_q, xl_d, xh_q, xh_d;
   logic [L_W-1:0] yl_q, yl_d, yh_q, yh_d;
   logic [2:0] data_q, data_d;
   logic busy_q, busy_d;
   logic drop_q, drop_d;

   logic [L_W-1:0] xl_in, xh_in, yl_in, yh_in, rs_in, re_in;
   logic done;

   always_comb begin
      xl_in = (i_x1 < i_x2) ? i_x1 : i_x2;
      xh_in = (i_x1 < i_x2) ? i_x2 : i_x1;
      yl_in = (i_y1 < i_y2) ? i_y1 : i_y2;
      yh_in = (i_y1 < i_y2) ? i_y2 : i_y1;
      rs_in = (i_ys < i_ye) ? i_ys : i_ye;
      re_in = (i_ys < i_ye) ? i_ye : i_ys;
   end

   // x_q/y_q always hold the pixel being presented this cycle
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      xl_d    = xl_q;
      xh_d    = xh_q;
      yl_d    = yl_q;
      yh_d    = yh_q;
      data_d  = data_q;
      busy_d  = busy_q;
      drop_d  = i_cmd_valid && (state_q != IDLE);
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_cmd_valid && i_ascii == '0) begin
               // clear reuses the row limits for rs/re
               state_d = CLEAR;
               yl_d    = rs_in;
               yh_d    = re_in;
               x_d     = '0;
               y_d     = rs_in;
               data_d  = 3'b000;
               busy_d  = 1'b1;
            end else if (i_cmd_valid && i_ascii == A_W'(1)) begin
`ifdef RECT_FILL_EN
               state_d = FILL;
`else
               state_d = TOP;
`endif
               xl_d   = xl_in;
               xh_d   = xh_in;
               yl_d   = yl_in;
               yh_d   = yh_in;
               x_d    = xl_in;
               y_d    = yl_in;
               data_d = i_color;
               busy_d = 1'b1;
            end
         end
         CLEAR: begin
            if (x_q == MAXV) begin
               x_d = '0;
               if (y_q == yh_q) done = 1'b1;
               else y_d = y_q + ONE;
            end else begin
               x_d = x_q + ONE;
            end
         end
         TOP: begin
            if (x_q != xh_q) begin
               x_d = x_q + ONE;
            end else if (yh_q != yl_q) begin
               state_d = BOTTOM;
               x_d     = xl_q;
               y_d     = yh_q;
            end else begin
               done = 1'b1;
            end
         end
         BOTTOM: begin
            if (x_q != xh_q) begin
               x_d = x_q + ONE;
            end else if (yh_q - yl_q >= TWO) begin
               state_d = LEFT;
               x_d     = xl_q;
               y_d     = yl_q + ONE;
            end else begin
               done = 1'b1;
            end
         end
         LEFT: begin
            if (y_q != yh_q - ONE) begin
               y_d = y_q + ONE;
            end else if (xh_q != xl_q) begin
               state_d = RIGHT;
               x_d     = xh_q;
               y_d     = yl_q + ONE;
            end else begin
               done = 1'b1;
            end
         end
         RIGHT: begin
            if (y_q != yh_q - ONE) y_d = y_q + ONE;
            else done = 1'b1;
         end
`ifdef RECT_FILL_EN
         FILL: begin
            if (x_q != xh_q) begin
               x_d = x_q + ONE;
            end else if (y_q != yh_q) begin
               x_d = xl_q;
               y_d = y_q + ONE;
            end else begin
               done = 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
      if (done) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         x_d     = '0;
         y_d     = '0;
         data_d  = 3'b000;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         xl_q    <= '0;
         xh_q    <= '0;
         yl_q    <= '0;
         yh_q    <= '0;
         data_q  <= 3'b000;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xl_q    <= xl_d;
         xh_q    <= xh_d;
         yl_q    <= yl_d;
         yh_q    <= yh_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign o_wr_en   = busy_q;
   assign o_busy    = busy_q;
   assign o_wr_addr = {y_q, x_q};
   assign o_wr_data = data_q;
   assign o_drop    = drop_q;

endmodule

// File: tb/tb_show_rect_draw.sv
// Randomised bench for show_rect_draw against a pixel-list reference model.
// Build with +define+RECT_FILL_EN to check the filled-rectangle variant.
module tb_show_rect_draw;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        i_cmd_valid = 1'b0;
   logic [7:0]  i_ascii = '0;
   logic [2:0]  i_color = '0;
   logic [7:0]  i_ys = '0, i_ye = '0;
   logic [7:0]  i_x1 = '0, i_y1 = '0, i_x2 = '0, i_y2 = '0;
   logic        o_wr_en;
   logic [15:0] o_wr_addr;
   logic [2:0]  o_wr_data;
   logic        o_busy;
   logic        o_drop;

   show_rect_draw dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .i_cmd_valid(i_cmd_valid),
      .i_ascii(i_ascii), .i_color(i_color), .i_ys(i_ys), .i_ye(i_ye),
      .i_x1(i_x1), .i_y1(i_y1), .i_x2(i_x2), .i_y2(i_y2),
      .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
      .o_busy(o_busy), .o_drop(o_drop)
   );

   always #5 sys_clk = ~sys_clk;

   int tests = 0;
   int fails = 0;

   // queued pixels still to be presented, {y, x, colour}
   logic [18:0] expq[$];
   bit exp_drop = 1'b0;
   bit was_busy;
   bit eb;

   int wr_cnt, busy_cyc, drop_cnt;
   int first_addr, last_addr;
   bit hit_15_6;

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic void push_px(int x, int y, int c);
      logic [7:0] xb, yb;
      logic [2:0] cb;
      xb = x[7:0];
      yb = y[7:0];
      cb = c[2:0];
      expq.push_back({yb, xb, cb});
   endfunction

   function automatic void model_clear(int ys, int ye);
      int rs, re;
      rs = (ys < ye) ? ys : ye;
      re = (ys < ye) ? ye : ys;
      for (int y = rs; y <= re; y++)
         for (int x = 0; x < 256; x++) push_px(x, y, 0);
   endfunction

   function automatic void model_rect(int x1, int y1, int x2, int y2, int c);
      int xl, xh, yl, yh;
      xl = (x1 < x2) ? x1 : x2;
      xh = (x1 < x2) ? x2 : x1;
      yl = (y1 < y2) ? y1 : y2;
      yh = (y1 < y2) ? y2 : y1;
`ifdef RECT_FILL_EN
      for (int y = yl; y <= yh; y++)
         for (int x = xl; x <= xh; x++) push_px(x, y, c);
`else
      for (int x = xl; x <= xh; x++) push_px(x, yl, c);
      if (yh != yl)
         for (int x = xl; x <= xh; x++) push_px(x, yh, c);
      if (yh - yl >= 2) begin
         for (int y = yl + 1; y < yh; y++) push_px(xl, y, c);
         if (xh != xl)
            for (int y = yl + 1; y < yh; y++) push_px(xh, y, c);
      end
`endif
   endfunction

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         expq.delete();
         exp_drop = 1'b0;
      end else begin
         was_busy = expq.size() > 0;
         if (was_busy) void'(expq.pop_front());
         exp_drop = 1'b0;
         if (i_cmd_valid) begin
            if (was_busy) exp_drop = 1'b1;
            else if (i_ascii == 8'd0) model_clear(int'(i_ys), int'(i_ye));
            else if (i_ascii == 8'd1)
               model_rect(int'(i_x1), int'(i_y1), int'(i_x2), int'(i_y2),
                          int'(i_color));
         end
      end
   end

   always @(negedge sys_clk) begin
      eb = expq.size() > 0;
      chk("busy", int'(o_busy), int'(eb));
      chk("wr_en", int'(o_wr_en), int'(eb));
      chk("drop", int'(o_drop), int'(exp_drop));
      if (eb) begin
         chk("addr", int'(o_wr_addr), int'(expq[0][18:3]));
         chk("data", int'(o_wr_data), int'(expq[0][2:0]));
      end
      if (o_wr_en) begin
         if (wr_cnt == 0) first_addr = int'(o_wr_addr);
         last_addr = int'(o_wr_addr);
         wr_cnt++;
         if (o_wr_addr == 16'h060F) hit_15_6 = 1'b1;
      end
      if (o_busy) busy_cyc++;
      if (o_drop) drop_cnt++;
   end

   task automatic clr_stats();
      #1;
      wr_cnt = 0;
      busy_cyc = 0;
      drop_cnt = 0;
      first_addr = -1;
      last_addr = -1;
      hit_15_6 = 1'b0;
   endtask

   task automatic send(int a, int c, int ys, int ye,
                       int x1, int y1, int x2, int y2);
      @(negedge sys_clk);
      i_ascii = a[7:0];
      i_color = c[2:0];
      i_ys = ys[7:0];
      i_ye = ye[7:0];
      i_x1 = x1[7:0];
      i_y1 = y1[7:0];
      i_x2 = x2[7:0];
      i_y2 = y2[7:0];
      i_cmd_valid = 1'b1;
      @(negedge sys_clk);
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(int limit);
      int n;
      n = 0;
      while (o_busy && n < limit) begin
         @(negedge sys_clk);
         n++;
      end
      if (o_busy) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles", limit);
      end
   endtask

   function automatic int clamp(int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   initial begin
      int r, a, p, q2, s;
      repeat (3) @(negedge sys_clk);
      chk("rst_wr_en", int'(o_wr_en), 0);
      chk("rst_addr", int'(o_wr_addr), 0);
      chk("rst_data", int'(o_wr_data), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_drop", int'(o_drop), 0);
      #2 sys_rst = 1'b0;

      clr_stats();
      send(0, 7, 10, 9, 0, 0, 0, 0);
      wait_idle(2000);
      chk("clr_writes", wr_cnt, 512);
      chk("clr_first", first_addr, 'h0900);
      chk("clr_last", last_addr, 'h0AFF);
      chk("clr_busy_cyc", busy_cyc, 512);

      clr_stats();
      send(1, 3, 0, 0, 20, 5, 10, 8);
      wait_idle(200);
`ifdef RECT_FILL_EN
      chk("rect_writes", wr_cnt, 44);
`else
      chk("rect_writes", wr_cnt, 26);
      chk("rect_no_15_6", int'(hit_15_6), 0);
`endif
      chk("rect_first", first_addr, 'h050A);

      clr_stats();
      send(1, 5, 0, 0, 7, 7, 7, 7);
      wait_idle(50);
      chk("dot_writes", wr_cnt, 1);
      chk("dot_addr", first_addr, 'h0707);

      clr_stats();
      send(1, 6, 0, 0, 0, 3, 255, 3);
      wait_idle(400);
      chk("row_writes", wr_cnt, 256);
      chk("row_last", last_addr, 'h03FF);
      repeat (3) @(negedge sys_clk);
      chk("row_no_wrap", wr_cnt, 256);

      clr_stats();
      send(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge sys_clk);
      send(1, 2, 0, 0, 1, 1, 9, 9);
      wait_idle(400);
      repeat (3) @(negedge sys_clk);
      chk("drop_pulses", drop_cnt, 1);
      chk("drop_clr_writes", wr_cnt, 256);

      clr_stats();
      send(5, 1, 0, 0, 1, 1, 4, 4);
      repeat (3) @(negedge sys_clk);
      chk("ign_writes", wr_cnt, 0);
      chk("ign_drop", drop_cnt, 0);

      send(1, 5, 0, 0, 0, 0, 3, 10);
      repeat (11) @(negedge sys_clk);
      #2 sys_rst = 1'b1;
      #1;
      chk("midrst_wr_en", int'(o_wr_en), 0);
      chk("midrst_busy", int'(o_busy), 0);
      @(negedge sys_clk);
      #2 sys_rst = 1'b0;
      clr_stats();
      send(1, 6, 0, 0, 1, 1, 2, 2);
      wait_idle(50);
      chk("post_rst_writes", wr_cnt, 4);
      chk("post_rst_first", first_addr, 'h0101);

`ifdef RECT_FILL_EN
      clr_stats();
      send(1, 2, 0, 0, 2, 2, 4, 3);
      wait_idle(50);
      chk("fill_writes", wr_cnt, 6);
      chk("fill_first", first_addr, 'h0202);
      chk("fill_last", last_addr, 'h0304);
`endif

      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         if (r < 3) a = 0;
         else if (r < 8) a = 1;
         else a = $urandom_range(2, 255);
         p = $urandom_range(0, 255);
         q2 = clamp(p + $urandom_range(0, 20) - 10);
         s = $urandom_range(0, 255);
         if (a == 0) begin
            q2 = clamp(p + $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) send(a, 3, q2, p, 0, 0, 0, 0);
            else send(a, 3, p, q2, 0, 0, 0, 0);
         end else begin
            send(a, $urandom_range(0, 7), 0, 0, p, s, q2,
                 clamp(s + $urandom_range(0, 20) - 10));
         end
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 5))
            @(negedge sys_clk);
         else wait_idle(2000);
      end
      wait_idle(2000);
      repeat (3) @(negedge sys_clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/show_rect_draw.md
# show_rect_draw

- Consumes the draw commands issued by the rect/ASCII show controller (clear-rows and rectangle commands) and rasterises them into pixel writes for the 256×256 overlay RAM.
- Sits between the show controller and the overlay RAM write port.
- Character commands (ASCII code ≥ 2) are ignored here; the glyph writer handles them.
- One command is processed at a time; commands that arrive while busy are dropped and flagged.

## Interface
Parameters:
- A_W, `ASCII_WIDTH (8): command code width
- L_W, `LETTER_PIXEL_WIDTH (8): coordinate width; frame is 2^L_W × 2^L_W

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- i_cmd_valid  in  1  one-cycle command strobe
- i_ascii  in  A_W  command code: 0 = clear rows, 1 = rectangle, other = ignore
- i_color  in  3  rectangle colour
- i_ys, i_ye  in  L_W  clear row range (inclusive)
- i_x1, i_y1, i_x2, i_y2  in  L_W  rectangle corners (inclusive, any order)
- o_wr_en  out  1  RAM write strobe
- o_wr_addr  out  2*L_W  {y, x}
- o_wr_data  out  3  pixel colour
- o_busy  out  1  command in progress
- o_drop  out  1  one-cycle pulse: a valid command was rejected

## Operation
- States: IDLE, CLEAR, TOP, BOTTOM, LEFT, RIGHT, plus FILL when the fill macro is set.
- Accept rule: the command is accepted when i_cmd_valid=1 and the state is IDLE.
  - At acceptance all inputs are latched and normalised: xl=min(x1,x2), xh=max; yl=min(y1,y2), yh=max; rs=min(ys,ye), re=max.
- i_ascii=0 → CLEAR:
  - Writes colour 3'b000 to every x in 0..2^L_W-1 for rows rs..re, row-major with x incrementing.
  - Total writes: (re-rs+1)·2^L_W.
- i_ascii=1 → outline, with no pixel written twice:
  - TOP: y=yl, x=xl..xh.
  - BOTTOM: y=yh, x=xl..xh. Skipped if yh==yl.
  - LEFT: x=xl, y=yl+1..yh-1. Skipped if yh-yl<2.
  - RIGHT: x=xh, y=yl+1..yh-1. Skipped if yh-yl<2 or xh==xl.
  - Data is the latched i_color.
- i_ascii ≥ 2 with valid: no action, no drop, state stays IDLE.
- Valid while busy: the command is ignored and o_drop pulses the next cycle. The running command is unaffected.
- Counter wrap: x/y counters are L_W wide. End conditions are compared against the latched limit before incrementing, so x=255 or y=255 terminates cleanly with no wrap.
- Reset mid-command: abort immediately; all outputs go to reset values and the state returns to IDLE.

## Timing
- Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_drop=0, state IDLE.
- Command accepted at edge N:
  - o_busy=1 from N+1.
  - The first write is presented (o_wr_en=1) at N+1.
  - One write per cycle, with no gaps between states.
- o_busy falls in the cycle after the last write. The next command can be accepted on the edge where o_busy is seen 0.
- All outputs are registered; the RAM samples o_wr_* on the edge following assertion.
- Outline latency = 1 + writes, where writes = (xh-xl+1)·(yh>yl ? 2 : 1) + (yh-yl≥2 ? (yh-yl-1)·(xh>xl ? 2 : 1) : 0).

## Configuration
- RECT_FILL_EN defined: a rectangle command enters FILL and writes every pixel of x=xl..xh, y=yl..yh, row-major. Writes = (xh-xl+1)·(yh-yl+1). TOP/BOTTOM/LEFT/RIGHT are unused.
- RECT_FILL_EN undefined: outline behaviour as in Operation. The FILL state is not compiled.

## Test plan
- Clear: ascii=0, ys=10, ye=9 → rows 9..10 cleared, 512 writes, addr 0x0900..0x0AFF in order, data 0; busy high for exactly 512 cycles.
- Outline: ascii=1, (x1,y1,x2,y2)=(20,5,10,8), colour 3'b011 → corners normalised to (10,5)-(20,8); 11+11+2+2=26 unique writes; pixel (15,6) not written.
- Degenerate: (7,7,7,7) → exactly 1 write, addr 0x0707. (0,3,255,3) → 256 writes on row 3, then busy drops without x wrap.
- Drop: second valid (ascii=1) 3 cycles into a running clear → o_drop pulses once; the clear completes with its full write count; the second rectangle is never drawn.
- Reset mid-rectangle: assert sys_rst during LEFT → o_wr_en=0 and o_busy=0 immediately; a new command after release executes normally.
- With RECT_FILL_EN: (2,2,4,3), colour 3'b010 → 6 writes in order (2,2),(3,2),(4,2),(2,3),(3,3),(4,3).
